// File: rtl/word_serializer_fifo.sv
// Byte-granular circular FIFO: accepts NBYTES-wide words, returns them one byte per read, MSB first.
// Define FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module word_serializer_fifo #(
  parameter int DBIT      = 8,
  parameter int NBYTES    = 2,
  parameter int ADDR_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [DBIT*NBYTES-1:0] w_data,
  input  logic                   rd,
  output logic [DBIT-1:0]        r_data,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_BITS:0]     count
`ifdef FIFO_ERROR_FLAGS_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   NBYTES_W  = (ADDR_BITS + 1)'(NBYTES);
  localparam logic [ADDR_BITS-1:0] PTR_STEP  = ADDR_BITS'(NBYTES);

  logic [DBIT-1:0]      mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_reg;
  logic [ADDR_BITS-1:0] rd_ptr_reg;
  logic [ADDR_BITS:0]   count_reg;
  logic [ADDR_BITS:0]   count_next;
  logic [DBIT-1:0]      r_data_reg;
  logic [ADDR_BITS:0]   free_space;
  logic                 wr_acc;
  logic                 rd_acc;

  logic [DBIT-1:0]      byte_lane [NBYTES];
  logic [ADDR_BITS-1:0] byte_addr [NBYTES];

  // Lane 0 carries the most-significant byte so it lands first in read order.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign byte_lane[gi] = w_data[DBIT*(NBYTES-gi)-1 -: DBIT];
      assign byte_addr[gi] = wr_ptr_reg + ADDR_BITS'(gi);
    end
  endgenerate

  assign free_space = DEPTH_W - count_reg;
  assign wr_acc     = wr && (free_space >= NBYTES_W);
  assign rd_acc     = rd && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (wr_acc) count_next = count_next + NBYTES_W;
    if (rd_acc) count_next = count_next - (ADDR_BITS + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      for (int k = 0; k < NBYTES; k++) begin
        mem[byte_addr[k]] <= byte_lane[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      r_data_reg <= '0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PTR_STEP;
      if (rd_acc) begin
        r_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + ADDR_BITS'(1);
      end
      count_reg <= count_next;
    end
  end

  assign r_data = r_data_reg;
  assign count  = count_reg;
  assign empty  = (count_reg == '0);
  assign full   = (free_space < NBYTES_W);

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr && !wr_acc) overflow_reg  <= 1'b1;
      if (rd && !rd_acc) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_word_serializer_fifo.sv
// Bench for word_serializer_fifo: directed plan plus random traffic against a byte-queue model.
module tb_word_serializer_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        wr = 1'b0, rd = 1'b0;
  logic [15:0] w_data = '0;
  logic [7:0]  r_data;
  logic        empty, full;
  logic [3:0]  count;

  logic        wr4 = 1'b0, rd4 = 1'b0;
  logic [31:0] w_data4 = '0;
  logic [7:0]  r_data4;
  logic        empty4, full4;
  logic [3:0]  count4;

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow, underflow, overflow4, underflow4;
`endif

  word_serializer_fifo #(.DBIT(8), .NBYTES(2), .ADDR_BITS(3)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .count(count)
`ifdef FIFO_ERROR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  word_serializer_fifo #(.DBIT(8), .NBYTES(4), .ADDR_BITS(3)) dut4 (
    .clk(clk), .reset(reset), .wr(wr4), .w_data(w_data4), .rd(rd4),
    .r_data(r_data4), .empty(empty4), .full(full4), .count(count4)
`ifdef FIFO_ERROR_FLAGS_EN
    , .overflow(overflow4), .underflow(underflow4)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO is just an ordered list of bytes.
  logic [7:0] q[$];
  logic [7:0] r_exp = 8'h00;
  bit         ovf_m = 1'b0;
  bit         udf_m = 1'b0;
  logic [7:0] prev_r, last_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit w, input logic [15:0] d, input bit r);
    bit wacc, racc;
    @(negedge clk);
    reset = rst; wr = w; w_data = d; rd = r;
    if (rst) begin
      q.delete();
      r_exp = 8'h00; ovf_m = 1'b0; udf_m = 1'b0;
    end else begin
      wacc = w && (8 - q.size() >= 2);
      racc = r && (q.size() != 0);
      if (w && !wacc) ovf_m = 1'b1;
      if (r && !racc) udf_m = 1'b1;
      if (racc) r_exp = q.pop_front();
      if (wacc) begin
        q.push_back(d[15:8]);
        q.push_back(d[7:0]);
      end
    end
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0d wr=%0d wd=%04h rd=%0d -> r_data=%02h count=%0d empty=%0d full=%0d",
             $time, rst, w, d, r, r_data, count, empty, full);
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full",  32'(full),  32'(8 - q.size() < 2));
    chk("r_data", 32'(r_data), 32'(r_exp));
`ifdef FIFO_ERROR_FLAGS_EN
    chk("overflow",  32'(overflow),  32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(udf_m));
`endif
    prev_r = last_r;
    last_r = r_data;
  endtask

  task automatic step4(input bit w, input logic [31:0] d, input bit r);
    @(negedge clk);
    wr4 = w; w_data4 = d; rd4 = r;
    @(posedge clk);
    #1;
    $display("t=%0t [n4] wr=%0d wd=%08h rd=%0d -> r_data=%02h count=%0d empty=%0d full=%0d",
             $time, w, d, r, r_data4, count4, empty4, full4);
  endtask

  logic [7:0] exp4 [8];

  initial begin
    exp4[0] = 8'hDE; exp4[1] = 8'hAD; exp4[2] = 8'hBE; exp4[3] = 8'hEF;
    exp4[4] = 8'h01; exp4[5] = 8'h02; exp4[6] = 8'h03; exp4[7] = 8'h04;

    // 1. reset, including reset mid-operation with wr/rd ignored
    step(1, 0, 16'h0000, 0);
    step(1, 0, 16'h0000, 0);
    chk("rst_rdata", 32'(r_data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst4_empty", 32'(empty4), 32'h1);
    chk("rst4_full", 32'(full4), 32'h0);
    step(0, 1, 16'h1234, 0);
    step(1, 1, 16'h5555, 1);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_rdata", 32'(r_data), 32'h0);

    // 2. single word, MSB first, then read on empty
    step(0, 1, 16'hA155, 0);
    step(0, 0, 16'h0000, 1);
    chk("t2_b0", 32'(r_data), 32'hA1);
    step(0, 0, 16'h0000, 1);
    chk("t2_b1", 32'(r_data), 32'h55);
    step(0, 0, 16'h0000, 1);
    chk("t2_hold", 32'(r_data), 32'h55);

    // 3. fill, drop on full, drain in order
    step(0, 1, 16'h0102, 0);
    step(0, 1, 16'h0304, 0);
    step(0, 1, 16'h0506, 0);
    step(0, 1, 16'h0708, 0);
    chk("t3_full", 32'(full), 32'h1);
    step(0, 1, 16'hFFFF, 0);
    chk("t3_drop_count", 32'(count), 32'h8);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 16'h0000, 1);
      chk("t3_order", 32'(r_data), 32'(i + 1));
    end

    // 4. pointer wrap-around
    step(0, 1, 16'h1112, 0);
    step(0, 1, 16'h1314, 0);
    step(0, 1, 16'h1516, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 1);
    chk("t4_fifth", 32'(r_data), 32'h15);
    step(0, 1, 16'h2122, 0);
    step(0, 1, 16'h2324, 0);
    step(0, 1, 16'h2526, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 16'h0000, 1);
    chk("t4_last", 32'(r_data), 32'h26);
    chk("t4_empty", 32'(empty), 32'h1);

    // 5. simultaneous wr+rd at count=7
    step(0, 1, 16'h3132, 0);
    step(0, 1, 16'h3334, 0);
    step(0, 1, 16'h3536, 0);
    step(0, 1, 16'h3738, 0);
    step(0, 0, 16'h0000, 1);
    chk("t5_c7", 32'(count), 32'h7);
    step(0, 1, 16'hBEEF, 1);
    chk("t5_drop", 32'(count), 32'h6);
    step(0, 1, 16'hCAFE, 1);
    chk("t5_both", 32'(count), 32'h7);
    for (int i = 0; i < 7; i++) step(0, 0, 16'h0000, 1);
    chk("t5_tail0", 32'(prev_r), 32'hCA);
    chk("t5_tail1", 32'(last_r), 32'hFE);

    // 6. four-byte words on the second instance
    step4(1, 32'hDEADBEEF, 0);
    step4(1, 32'h01020304, 0);
    chk("t6_full", 32'(full4), 32'h1);
    chk("t6_count", 32'(count4), 32'h8);
    step4(1, 32'h99999999, 0);
    chk("t6_drop", 32'(count4), 32'h8);
    for (int i = 0; i < 8; i++) begin
      step4(0, 32'h0, 1);
      chk("t6_order", 32'(r_data4), 32'(exp4[i]));
    end
    chk("t6_empty", 32'(empty4), 32'h1);
    step4(0, 32'h0, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           16'($urandom), $urandom_range(0, 1) == 1);
    end
    step(0, 0, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
